// File: rtl/uart_tx_device_if.sv
// Bus-side signal bundle for the memory-mapped UART transmitter.
// Ports: ABUS (address) and WE (write strobe); master = CPU side, slave = device.
interface uart_tx_device_if #(
    parameter int WBITS = 32
);
    logic [WBITS-1:0] ABUS;
    logic             WE;

    modport master (output ABUS, output WE);
    modport slave  (input  ABUS, input  WE);
endinterface

// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 serial transmitter with a small byte FIFO.
// Ports: CLK, RESET (async, active-high), bus (ABUS/WE), DBUS (tri-state data),
//        TXD (serial out, idle high), INTR (level interrupt = READY && IE).
module uart_tx_device #(
    parameter int               WBITS      = 32,
    parameter int               DBITS      = 8,
    parameter int               CBITS      = 5,
    parameter logic [WBITS-1:0] BASE       = 32'hF0000060,
    parameter int               CLK_DIV    = 781,
    parameter int               DEPTH_LOG2 = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    uart_tx_device_if.slave     bus,
    inout  wire  [WBITS-1:0]    DBUS,
    output logic                TXD,
    output logic                INTR
);

    localparam int               DEPTH = 1 << DEPTH_LOG2;
    localparam int               CW    = $clog2(CLK_DIV);
    localparam logic [CW-1:0]    CMAX  = CW'(CLK_DIV - 1);
    localparam logic [WBITS-1:0] CADDR = BASE + WBITS'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [DBITS-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;
    logic [DBITS-1:0]      head;

    logic sel_data;
    logic sel_ctrl;
    logic push;
    logic drop;
    logic pop;
    logic ovr;
    logic ie;
    logic ready;
    logic idle;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [2:0]       bitc;
    logic [2:0]       bitc_n;
    logic [DBITS-1:0] shift;
    logic [DBITS-1:0] shift_n;
    logic             txd_n;

    logic [CBITS-1:0] ctrl_val;
    logic [WBITS-1:0] rdata;
    logic             unused_bits;

    assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    assign sel_data = (bus.ABUS == BASE);
    assign sel_ctrl = (bus.ABUS == CADDR);

    // Fullness is judged on the pre-edge count, so a concurrent pop
    // does not rescue a write that hits a full FIFO.
    assign push = bus.WE && sel_data && !full;
    assign drop = bus.WE && sel_data && full;

    assign ready = !full;
    assign idle  = empty && (state == S_IDLE);
    assign INTR  = ready && ie;

    assign unused_bits = ^DBUS[WBITS-1:DBITS];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= DBUS[DBITS-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Overflow set takes priority over a same-edge clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ovr <= 1'b0;
            ie  <= 1'b0;
        end else begin
            if (drop) begin
                ovr <= 1'b1;
            end else if (bus.WE && sel_ctrl) begin
                ovr <= ovr & DBUS[1];
            end
            if (bus.WE && sel_ctrl) begin
                ie <= DBUS[4];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
            bitc  <= '0;
            shift <= '0;
            TXD   <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitc  <= bitc_n;
            shift <= shift_n;
            TXD   <= txd_n;
        end
    end

    // TXD is registered: txd_n is the line level for the state being entered.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitc_n  = bitc;
        shift_n = shift;
        txd_n   = TXD;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                txd_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    bitc_n  = '0;
                    cnt_n   = '0;
                    state_n = S_START;
                    txd_n   = 1'b0;
                end
            end
            S_START: begin
                if (cnt == CMAX) begin
                    cnt_n   = '0;
                    state_n = S_DATA;
                    txd_n   = shift[0];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == CMAX) begin
                    cnt_n = '0;
                    if (bitc == 3'd7) begin
                        state_n = S_STOP;
                        txd_n   = 1'b1;
                    end else begin
                        shift_n = {1'b0, shift[DBITS-1:1]};
                        bitc_n  = bitc + 3'd1;
                        txd_n   = shift[1];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == CMAX) begin
                    cnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        bitc_n  = '0;
                        state_n = S_START;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                        txd_n   = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

    assign ctrl_val = {ie, 1'b0, idle, ovr, ready};

    always_comb begin
        rdata = '0;
        if (sel_data) begin
            rdata = WBITS'(count);
        end else if (sel_ctrl) begin
            rdata = WBITS'(ctrl_val);
        end
    end

    assign DBUS = (!bus.WE && (sel_data || sel_ctrl)) ? rdata : 'z;

endmodule

// File: doc/uart_tx_device.md
# uart_tx_device

Memory-mapped serial transmitter on the processor's I/O bus: the CPU writes bytes to a DATA register, which queues them in a small FIFO, and the block shifts them out on TXD as 8N1 frames, LSB first. It is the output-direction counterpart of the bus-attached input devices. It uses the same DATA/CTRL register pair, the same tri-state DBUS read scheme and the same interrupt-enable convention. It lets the CPU emit characters without busy-waiting per bit.

## Interface
- WBITS, 32, bus address/data width
- DBITS, 8, character width (fixed 8 for 8N1)
- CBITS, 5, CTRL register width
- BASE, 32'hF0000060, DATA address; CTRL at BASE+4
- CLK_DIV, 781, CLK cycles per serial bit (≥2)
- DEPTH_LOG2, 2, FIFO depth = 2^DEPTH_LOG2

- CLK  input  1  clock
- RESET  input  1  reset, asynchronous, active-high
- ABUS  input  WBITS  bus address
- DBUS  inout  WBITS  bus data; driven only during reads of this device, else high-Z
- WE  input  1  bus write strobe
- TXD  output  1  serial out, idle high
- INTR  output  1  interrupt request, level

## Operation
- DATA (BASE):
  - Write: pushes DBUS[7:0] into the FIFO. If the FIFO is full (count==DEPTH, sampled before the edge), the byte is dropped and CTRL[1] is set. This holds even if a pop occurs on the same edge.
  - Read: returns zero-extended FIFO occupancy (DEPTH_LOG2+1 bits).
- CTRL (BASE+4), read value {IE, 0, IDLE, OVR, READY}:
  - bit0 READY = FIFO not full. Read-only.
  - bit1 OVR is sticky. A write ANDs it with DBUS[1]: writing 0 clears it, writing 1 leaves it unchanged.
  - bit2 IDLE = FIFO empty and FSM in IDLE. Read-only.
  - bit3 reads 0.
  - bit4 IE is read/write.
- A set of OVR and a CTRL write that clears it on the same edge: the set wins.
- INTR = READY && IE.
- DBUS drive: when !WE && ABUS==BASE it drives the DATA read value. When !WE && ABUS==BASE+4 it drives the CTRL read value. Otherwise it is high-Z.
- FSM states:
  - IDLE: TXD=1. If the FIFO is non-empty, pop into the shift register, clear the bit counter and go to START.
  - START: TXD=0 for CLK_DIV cycles, then go to DATA.
  - DATA: TXD=shift[0] for CLK_DIV cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: TXD=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop directly into START (no idle gap). Otherwise go to IDLE.
- Baud counter: $clog2(CLK_DIV) bits, counts 0..CLK_DIV-1 and wraps at the bit boundary. Bit counter: 3 bits.
- Push and pop on the same edge when not full: count unchanged, data order preserved. FIFO pointers wrap modulo DEPTH.
- TXD is a registered output.

## Timing
- Reset values:
  - TXD=1, INTR=0.
  - FIFO empty, count=0, FSM=IDLE, counters=0.
  - OVR=0, IE=0.
  - CTRL reads 0x05.
- The write takes effect on the CLK edge with WE && sel.
- Byte written at edge N into an empty FIFO with the FSM in IDLE: pop at edge N+1, and TXD falls after edge N+1.
- A frame is exactly 10*CLK_DIV cycles.
- Back-to-back frames: the next start bit immediately follows the last stop-bit cycle.
- READY/INTR update the cycle after the count changes.
- IDLE rises the cycle after the FSM returns to IDLE with the FIFO empty.
- Reads are combinational. DBUS is valid in the same cycle as ABUS/!WE.
- RESET mid-frame: TXD goes to 1 asynchronously, the frame is truncated, and queued bytes are discarded.

## Test plan
- Reset, then read CTRL -> 0x05. Read DATA -> 0. TXD=1, INTR=0. DBUS is Z for ABUS=BASE+8.
- CLK_DIV=4, write 0x55 -> TXD low 4 cycles starting 1 cycle after the write, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. IDLE=1 after 40 cycles.
- DEPTH_LOG2=2, six consecutive writes 0x01..0x06 -> 0x06 dropped, OVR=1, READY=0, DATA read=4. Bytes 01..05 are emitted with no idle gaps.
- Write CTRL 0x10 while empty -> INTR=1. Fill the FIFO -> INTR=0. Drain one byte -> INTR=1. Write CTRL 0x12 -> OVR kept. Write CTRL 0x10 -> OVR cleared.
- Assert RESET mid-data-bit while TXD=0 -> TXD=1 immediately. After release, CTRL=0x05 and no further frame.
- CPU write on the same edge as the STOP-end pop with FIFO count=1 -> count stays 1 and the byte order is preserved in the serial output.
